// File: rtl/tap_ctrl_ir.sv
// IEEE 1149.1 TAP controller with instruction register, BYPASS and optional IDCODE DR.
// Define TAP_IDCODE_EN to include the IDCODE register and make IDCODE the reset instruction.
module tap_ctrl_ir #(
  parameter int                  IR_WIDTH   = 5,
  parameter logic [IR_WIDTH-1:0] IDCODE_OP  = 5'b00001,
  parameter logic [31:0]         IDCODE_VAL = 32'h1000_0001
) (
  input  logic                tck,
  input  logic                trst,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  output logic [3:0]          state,
  output logic [IR_WIDTH-1:0] instr,
  input  logic                dr_tdo,
  output logic                capture_dr,
  output logic                shift_dr,
  output logic                update_dr,
  output logic                tlr
);

  localparam logic [3:0] TLR    = 4'hF;
  localparam logic [3:0] RTI    = 4'hC;
  localparam logic [3:0] SEL_DR = 4'h7;
  localparam logic [3:0] CAP_DR = 4'h6;
  localparam logic [3:0] SH_DR  = 4'h2;
  localparam logic [3:0] EX1_DR = 4'h1;
  localparam logic [3:0] PAU_DR = 4'h3;
  localparam logic [3:0] EX2_DR = 4'h0;
  localparam logic [3:0] UPD_DR = 4'h5;
  localparam logic [3:0] SEL_IR = 4'h4;
  localparam logic [3:0] CAP_IR = 4'hE;
  localparam logic [3:0] SH_IR  = 4'hA;
  localparam logic [3:0] EX1_IR = 4'h9;
  localparam logic [3:0] PAU_IR = 4'hB;
  localparam logic [3:0] EX2_IR = 4'h8;
  localparam logic [3:0] UPD_IR = 4'hD;

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);
`ifdef TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RESET_INSTR = IDCODE_OP;
`else
  localparam logic [IR_WIDTH-1:0] RESET_INSTR = '1;
`endif

  logic [3:0]          nextState;
  logic [IR_WIDTH-1:0] irShift;
  logic                bypassReg;
  logic                selBypass;
  logic                selUser;
  logic                drOut;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    nextState = state;
    case (state)
      TLR:    nextState = tms ? TLR    : RTI;
      RTI:    nextState = tms ? SEL_DR : RTI;
      SEL_DR: nextState = tms ? SEL_IR : CAP_DR;
      CAP_DR: nextState = tms ? EX1_DR : SH_DR;
      SH_DR:  nextState = tms ? EX1_DR : SH_DR;
      EX1_DR: nextState = tms ? UPD_DR : PAU_DR;
      PAU_DR: nextState = tms ? EX2_DR : PAU_DR;
      EX2_DR: nextState = tms ? UPD_DR : SH_DR;
      UPD_DR: nextState = tms ? SEL_DR : RTI;
      SEL_IR: nextState = tms ? TLR    : CAP_IR;
      CAP_IR: nextState = tms ? EX1_IR : SH_IR;
      SH_IR:  nextState = tms ? EX1_IR : SH_IR;
      EX1_IR: nextState = tms ? UPD_IR : PAU_IR;
      PAU_IR: nextState = tms ? EX2_IR : PAU_IR;
      EX2_IR: nextState = tms ? UPD_IR : SH_IR;
      UPD_IR: nextState = tms ? SEL_DR : RTI;
      default: nextState = TLR;
    endcase
  end

  // With IDCODE absent its opcode falls back to BYPASS rather than reaching the user DR.
`ifdef TAP_IDCODE_EN
  logic        selIdcode;
  logic [31:0] idcodeReg;
  assign selBypass = (instr == '1);
  assign selIdcode = !selBypass && (instr == IDCODE_OP);
  assign selUser   = !selBypass && !selIdcode;
`else
  assign selBypass = (instr == '1) || (instr == IDCODE_OP);
  assign selUser   = !selBypass;
`endif

  always_comb begin
    drOut = dr_tdo;
    if (selBypass) drOut = bypassReg;
`ifdef TAP_IDCODE_EN
    else if (selIdcode) drOut = idcodeReg[0];
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      state     <= TLR;
      irShift   <= IR_CAPTURE;
      bypassReg <= 1'b0;
    end else begin
      state <= nextState;
      if (state == CAP_IR) irShift <= IR_CAPTURE;
      else if (state == SH_IR) irShift <= {tdi, irShift[IR_WIDTH-1:1]};
      if (selBypass) begin
        if (state == CAP_DR) bypassReg <= 1'b0;
        else if (state == SH_DR) bypassReg <= tdi;
      end
    end
  end

`ifdef TAP_IDCODE_EN
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) idcodeReg <= IDCODE_VAL;
    else if (selIdcode) begin
      if (state == CAP_DR) idcodeReg <= IDCODE_VAL;
      else if (state == SH_DR) idcodeReg <= {tdi, idcodeReg[31:1]};
    end
  end
`endif

  // Outputs and the active instruction move on the falling edge so they are stable at the next rising edge.
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      instr      <= RESET_INSTR;
      tdo        <= 1'b0;
      tdo_en     <= 1'b0;
      capture_dr <= 1'b0;
      shift_dr   <= 1'b0;
      update_dr  <= 1'b0;
      tlr        <= 1'b1;
    end else begin
      if (state == UPD_IR) instr <= irShift;
      else if (state == TLR) instr <= RESET_INSTR;
      if (state == SH_IR) tdo <= irShift[0];
      else if (state == SH_DR) tdo <= drOut;
      tdo_en     <= (state == SH_IR) || (state == SH_DR);
      capture_dr <= (state == CAP_DR) && selUser;
      shift_dr   <= (state == SH_DR) && selUser;
      update_dr  <= (state == UPD_DR) && selUser;
      tlr        <= (state == TLR);
    end
  end

endmodule

// File: doc/tap_ctrl_ir.md
TAP_CTRL_IR -- requirements
Module: tap_ctrl_ir

Interface
REQ-001 The block SHALL have parameter IR_WIDTH, default 5, meaning instruction register width (minimum 2).
REQ-002 The block SHALL have parameter IDCODE_OP, default 5'b00001, meaning IDCODE opcode.
REQ-003 The block SHALL have parameter IDCODE_VAL, default 32'h1000_0001, meaning IDCODE register capture value (bit 0 SHALL be 1).
REQ-004 The block SHALL have port tck, input, 1, meaning test clock.
REQ-005 The block SHALL have port trst, input, 1, meaning test reset, asynchronous, active-low.
REQ-006 The block SHALL have port tms, input, 1, meaning mode select, sampled on tck rising edge.
REQ-007 The block SHALL have port tdi, input, 1, meaning serial data in, sampled on tck rising edge.
REQ-008 The block SHALL have port tdo, output, 1, meaning serial data out, changes on tck falling edge.
REQ-009 The block SHALL have port tdo_en, output, 1, meaning tdo drive enable.
REQ-010 The block SHALL have port state, output, 4, meaning current TAP state code.
REQ-011 The block SHALL have port instr, output, IR_WIDTH, meaning active (updated) instruction.
REQ-012 The block SHALL have port dr_tdo, input, 1, meaning serial out of the external DR selected by a user instruction.
REQ-013 The block SHALL have ports capture_dr, shift_dr and update_dr, each output, 1, meaning external DR strobes, valid while instr is a user opcode.
REQ-014 The block SHALL have port tlr, output, 1, meaning 1 while in Test-Logic-Reset.

Function
REQ-015 The state encoding SHALL be TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauIR B, Ex2IR 8, UpdIR D.
REQ-016 The state register SHALL advance on each tck rising edge per IEEE 1149.1 TMS transitions; five consecutive tms=1 edges SHALL reach TLR from any state.
REQ-017 The IR shift register (IR_WIDTH bits) SHALL load {zeros, 2'b01} on the tck rising edge leaving CapIR, and SHALL shift right with tdi into the MSB on each rising edge leaving ShIR.
REQ-018 instr SHALL load the IR shift register on the tck falling edge while in UpdIR, and SHALL hold in all other states.
REQ-019 The opcode with all bits 1 SHALL select BYPASS; IDCODE_OP SHALL select IDCODE; every other opcode SHALL select the external DR.
REQ-020 The BYPASS register (1 bit) SHALL capture 0 in CapDR and shift tdi in ShDR.
REQ-021 The IDCODE register (32 bits) SHALL capture IDCODE_VAL in CapDR and shift right with tdi into bit 31 in ShDR.
REQ-022 tdo SHALL be registered on the tck falling edge: in ShIR, IR bit 0; in ShDR, bit 0 of the selected DR (dr_tdo for a user opcode); otherwise it SHALL hold.
REQ-023 tdo_en SHALL be registered on the tck falling edge, equal to 1 exactly while state is ShIR or ShDR.
REQ-024 capture_dr and shift_dr SHALL be registered on the tck falling edge, equal to (state==CapDR) and (state==ShDR) respectively, gated by a user opcode.
REQ-025 update_dr SHALL be registered on the tck falling edge, equal to (state==UpdDR) gated by a user opcode.
REQ-026 tlr SHALL be registered on the tck falling edge, equal to (state==F).
REQ-027 Entering TLR via tms (not trst) SHALL set instr to the reset instruction on the next tck falling edge.
REQ-028 Pause/Exit2 states SHALL preserve all shift register contents.

Reset
REQ-029 While trst=0: state=F, IR shift register={zeros,01}, instr=reset instruction, tdo=0, tdo_en=0, capture_dr=shift_dr=update_dr=0, tlr=1, BYPASS=0, IDCODE=IDCODE_VAL.
REQ-030 Asserting trst mid-shift SHALL abort immediately with no update of instr or update_dr pulse.

Configuration
REQ-031 With macro TAP_IDCODE_EN defined, the IDCODE register SHALL be present and the reset instruction SHALL be IDCODE_OP.
REQ-032 With TAP_IDCODE_EN undefined, the IDCODE register SHALL be absent, IDCODE_OP SHALL decode as BYPASS, and the reset instruction SHALL be all-ones.

Verification
REQ-033 The bench SHALL cover: from any state, tms=1 for 5 tck -> state=F, tlr=1.
REQ-034 The bench SHALL cover: reset, tms 0,1,0,0 then shift 32 bits -> tdo emits 32'h1000_0001 LSB-first (TAP_IDCODE_EN).
REQ-035 The bench SHALL cover: scan IR 5'b11111, Update-IR, shift DR with tdi=1,0,1 -> tdo=0,1,0 (one-bit delay).
REQ-036 The bench SHALL cover: IR scan of 5 bits -> tdo first shows 1,0,0,0,0 (captured 01 pattern), and instr equals the shifted value after UpdIR.
REQ-037 The bench SHALL cover: user opcode 5'b00010, DR scan -> capture_dr one cycle, shift_dr for n cycles, tdo follows dr_tdo, then one update_dr pulse.
REQ-038 The bench SHALL cover: trst=0 during ShIR -> instr unchanged from reset instruction and tdo_en=0 immediately.
